layer_sequencer: RTL

- Game-phase controller for the per-pixel layer priority mux.
- Runs the shot cycle: aim, roll, pocket blink, foul blink.
- Gates the line, white ball, red ball and hole-number draw requests before they reach the mux, so layers are hidden or blinked per phase.
- Emits round/respawn pulses to the ball logic. Frame-timed via startOfFrame.

---
 rtl/layer_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/layer_sequencer.sv
// Shot-cycle phase controller: sequences aim/roll/blink phases and gates the
// layer draw requests feeding the priority mux.
module layer_sequencer #(
    parameter int BLINK_FRAMES        = 8,
    parameter int BLINK_TOGGLES       = 6,
    parameter int ROLL_TIMEOUT_FRAMES = 600
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       shotFired,
    input  logic       ballsStopped,
    input  logic       redPocketed,
    input  logic       whitePocketed,
    input  logic       lineDRIn,
    input  logic       whiteBallDRIn,
    input  logic       redBallDRIn,
    input  logic       holeNumberDRIn,
    output logic       lineDR,
    output logic       whiteBallDR,
    output logic       redBallDR,
    output logic       holeNumberDR,
    output logic [1:0] gameState,
    output logic       shotEnable,
    output logic       newRound,
    output logic       respawnWhite
);

    localparam int CNT_MAX = (BLINK_FRAMES > ROLL_TIMEOUT_FRAMES) ? BLINK_FRAMES : ROLL_TIMEOUT_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TOG_W   = $clog2(BLINK_TOGGLES + 1);

    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] ROLL_LAST  = CNT_W'(ROLL_TIMEOUT_FRAMES - 1);
    localparam logic [TOG_W-1:0] TOG_LAST   = TOG_W'(BLINK_TOGGLES - 1);

    typedef enum logic [1:0] {
        AIM        = 2'd0,
        ROLL       = 2'd1,
        WIN_BLINK  = 2'd2,
        FOUL_BLINK = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] frame_cnt, frame_next;
    logic [TOG_W-1:0] toggle_cnt, toggle_next;
    logic             blink_vis, blink_next;
    logic [3:0]       vis, vis_next;
    logic             new_round_next, respawn_next;

    // Layer enables ordered {line, white, red, hole}.
    function automatic logic [3:0] layer_vis(input state_t s, input logic bv);
        logic [3:0] v;
        case (s)
            AIM:        v = 4'b1111;
            ROLL:       v = 4'b0111;
            WIN_BLINK:  v = {1'b0, 1'b1, 1'b0, bv};
            FOUL_BLINK: v = {1'b0, bv, 1'b1, 1'b1};
            default:    v = 4'b1111;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= AIM;
            frame_cnt    <= '0;
            toggle_cnt   <= '0;
            blink_vis    <= 1'b0;
            vis          <= 4'b1111;
            newRound     <= 1'b0;
            respawnWhite <= 1'b0;
        end else begin
            state        <= state_next;
            frame_cnt    <= frame_next;
            toggle_cnt   <= toggle_next;
            blink_vis    <= blink_next;
            vis          <= vis_next;
            newRound     <= new_round_next;
            respawnWhite <= respawn_next;
        end
    end

    always_comb begin
        state_next     = state;
        frame_next     = frame_cnt;
        toggle_next    = toggle_cnt;
        blink_next     = blink_vis;
        new_round_next = 1'b0;
        respawn_next   = 1'b0;

        case (state)
            AIM: begin
                if (shotFired) begin
                    state_next  = ROLL;
                    frame_next  = '0;
                    toggle_next = '0;
                end
            end
            ROLL: begin
                // Pocket events outrank rest/timeout; foul outranks win.
                if (whitePocketed) begin
                    state_next  = FOUL_BLINK;
                    frame_next  = '0;
                    toggle_next = '0;
                    blink_next  = 1'b0;
                end else if (redPocketed) begin
                    state_next  = WIN_BLINK;
                    frame_next  = '0;
                    toggle_next = '0;
                    blink_next  = 1'b0;
                end else if (ballsStopped) begin
                    state_next  = AIM;
                    frame_next  = '0;
                    toggle_next = '0;
                end else if (startOfFrame) begin
                    if (frame_cnt == ROLL_LAST) begin
                        state_next  = AIM;
                        frame_next  = '0;
                        toggle_next = '0;
                    end else begin
                        frame_next = frame_cnt + CNT_W'(1);
                    end
                end
            end
            WIN_BLINK, FOUL_BLINK: begin
                if (startOfFrame) begin
                    if (frame_cnt == BLINK_LAST) begin
                        frame_next = '0;
                        blink_next = ~blink_vis;
                        if (toggle_cnt == TOG_LAST) begin
                            state_next     = AIM;
                            toggle_next    = '0;
                            new_round_next = (state == WIN_BLINK);
                            respawn_next   = (state == FOUL_BLINK);
                        end else begin
                            toggle_next = toggle_cnt + TOG_W'(1);
                        end
                    end else begin
                        frame_next = frame_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_next = AIM;
        endcase

        vis_next = layer_vis(state_next, blink_next);
    end

    // Gating stays combinational so mux pixel alignment is untouched.
    assign lineDR       = lineDRIn       & vis[3];
    assign whiteBallDR  = whiteBallDRIn  & vis[2];
    assign redBallDR    = redBallDRIn    & vis[1];
    assign holeNumberDR = holeNumberDRIn & vis[0];

    assign gameState  = state;
    assign shotEnable = (state == AIM);

endmodule
